// File: rtl/regfile_pkg.sv
// Shared types and default widths for the decode-stage register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: zero-register check, writeback bypass and pending mask.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              run_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0] entry_i,
  input  logic              pending_i,
  output logic [DATA_W-1:0] data_o,
  output logic              pending_o
);

  logic is_zero;
  logic hit;

  assign is_zero = ZERO_REG && (addr_i == '0);
  assign hit     = we_i && (wr_addr_i == addr_i);

  always_comb begin
    data_o    = '0;
    pending_o = 1'b0;
    if (run_i && !is_zero) begin
      data_o    = hit ? wr_data_i : entry_i;
      // A retiring write clears the hazard in the same cycle it lands.
      pending_o = pending_i && !hit;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with scoreboard pending bits and a post-reset
// zeroing sweep that writes one entry per cycle so storage can map to RAM.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              run;
  logic              wr_valid;
  logic              set_valid;

  assign run       = (state_q == StRun);
  assign ready     = run;
  assign wr_valid  = run && we && !(ZERO_REG && (wr_addr == '0));
  assign set_valid = run && set_en && !(ZERO_REG && (set_addr == '0));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      StInit: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d = StRun;
        end
      end
      StRun: begin
        mem_we = wr_valid;
      end
      default: begin
        state_d = StInit;
      end
    endcase
  end

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (wr_valid) begin
      pending_d[wr_addr] = 1'b0;
    end
    if (set_valid) begin
      pending_d[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StInit;
      ptr_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rdport
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .run_i     (run),
      .addr_i    (addr),
      .we_i      (we),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .entry_i   (mem_q[addr]),
      .pending_i (pending_q[addr]),
      .data_o    (rd_data[i*DATA_W +: DATA_W]),
      .pending_o (rd_pending[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb against an array-based model of the register file rules.
module tb_regfile_sb;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             set_en;
  logic [AW-1:0]    set_addr;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pending;
  logic             ready;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .set_en     (set_en),
    .set_addr   (set_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .ready      (ready)
  );

  // Model: contents are all zero once the sweep finishes; sweep_left counts edges to ready.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  int            m_sweep = DEPTH;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic w, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic s, input logic [AW-1:0] sa,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    reset    = rst;
    we       = w;
    wr_addr  = wa;
    wr_data  = wd;
    set_en   = s;
    set_addr = sa;
    rd_addr  = {a1, a0};
    #2;
    check_eq("ready", ready, (m_sweep == 0));
    for (int i = 0; i < NR; i++) begin
      a = (i == 0) ? a0 : a1;
      if (m_sweep != 0 || a == 0) begin
        ed = '0;
        ep = 1'b0;
      end else if (w && wa == a) begin
        ed = wd;
        ep = 1'b0;
      end else begin
        ed = m_mem[a];
        ep = m_pend[a];
      end
      check_eq($sformatf("rd_data%0d[r%0d]", i, a), rd_data[i*DW +: DW], ed);
      check_eq($sformatf("rd_pending%0d[r%0d]", i, a), rd_pending[i], ep);
    end
    @(posedge clk);
    if (!rst) begin
      m_sweep = DEPTH;
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[k]  = '0;
        m_pend[k] = 1'b0;
      end
    end else if (m_sweep > 0) begin
      m_sweep--;
    end else begin
      if (w && wa != 0) begin
        m_mem[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (s && sa != 0) begin
        m_pend[sa] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic rand_step(input logic rst);
    step(rst, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom,
         1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
         AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)));
  endtask

  task automatic idle(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, a0, a1);
  endtask

  initial begin
    reset    = 1'b0;
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    set_en   = 1'b0;
    set_addr = '0;
    rd_addr  = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) begin
      m_mem[k]  = '0;
      m_pend[k] = 1'b0;
    end
    m_sweep = DEPTH;

    // Reset held, then the full sweep with ignored writes/issues.
    repeat (3) rand_step(1'b0);
    repeat (DEPTH + 2) rand_step(1'b1);

    // Bypass then storage read.
    step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd0);
    idle(5'd0, 5'd5);

    // Zero register is never written nor pending.
    step(1'b1, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Pending set, cleared by writeback with same-cycle bypass.
    step(1'b1, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd7);
    idle(5'd7, 5'd3);
    step(1'b1, 1'b1, 5'd7, 32'h55, 1'b0, '0, 5'd7, 5'd7);
    idle(5'd7, 5'd7);

    // Same-cycle set and write: set wins, data still written.
    step(1'b1, 1'b1, 5'd9, 32'hCAFE0009, 1'b1, 5'd9, 5'd9, 5'd1);
    idle(5'd9, 5'd9);

    // Reset mid-sweep at ptr 10, then full sweep.
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd9);
    repeat (10) rand_step(1'b1);
    rand_step(1'b0);
    repeat (DEPTH + 1) rand_step(1'b1);

    // Random traffic in RUN, then reset and confirm everything reads zero.
    repeat (300) rand_step(1'b1);
    rand_step(1'b0);
    repeat (DEPTH) rand_step(1'b1);
    for (int k = 0; k < DEPTH; k += 2) begin
      idle(AW'(k), AW'(k + 1));
    end

    repeat (300) rand_step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
